// File: rtl/hazard_sequencer.sv
// Hazard and control-flow sequencer: shadows ID decode facts through EX/MEM/WB
// and drives stall, flush, PC-select, return-stack and forwarding controls.
module hazard_sequencer #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_src_a,
  input  logic [REG_AW-1:0] id_src_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              id_use_imm,
  input  logic              id_reg_write,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_is_load,
  input  logic              id_is_store,
  input  logic              id_jump,
  input  logic              id_branch_taken,
  input  logic              id_call,
  input  logic              id_ret,
  output logic              pc_writebar,
  output logic              IF_ID_loadbar,
  output logic              IF_ID_flush,
  output logic              ID_EX_flush,
  output logic [1:0]        pc_mux,
  output logic              push,
  output logic              pop,
  output logic [1:0]        forward_A,
  output logic [1:0]        forward_B,
  output logic [1:0]        forward_mem_EX,
  output logic              forward_mem_MEM,
  output logic [CNT_W-1:0]  stall_cycles
);

  // state    | meaning
  // S_RUN    | normal issue; hazards and ID-resolved control transfers handled
  // S_RET_WAIT | RET held in ID for one cycle after the pop; redirect to stack_out
  typedef enum logic {S_RUN, S_RET_WAIT} state_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              is_load;
    logic              is_store;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] src_a;
    logic [REG_AW-1:0] src_b;
    logic              use_a;
    logic              use_b;
    logic              use_imm;
  } slot_t;

  state_t           r_state, w_state_nxt;
  slot_t            r_ex, r_mem, r_wb;
  slot_t            w_id;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_hazard, w_stall;
  logic             w_unused;

  function automatic logic f_match(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid & s.reg_write & (s.dst == r);
  endfunction

  // MEM beats WB; a load still in MEM has no data yet, so it never forwards from EX_MEM.
  function automatic logic [1:0] f_fwd(input slot_t m, input slot_t w,
                                       input logic [REG_AW-1:0] r);
    if (f_match(m, r) && !m.is_load) return 2'b10;
    else if (f_match(w, r))          return 2'b11;
    else                             return 2'b00;
  endfunction

  assign w_id = {1'b1, id_reg_write, id_is_load, id_is_store, id_dst,
                 id_src_a, id_src_b, id_use_a, id_use_b, id_use_imm};

  assign w_hazard = r_ex.valid & r_ex.reg_write & r_ex.is_load &
                    ((id_use_a & (r_ex.dst == id_src_a)) |
                     (id_use_b & (r_ex.dst == id_src_b) & !id_is_store));
  assign w_stall  = (r_state == S_RUN) & w_hazard;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= ID_EX_flush ? '0 : w_id;
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:
        if (!w_hazard && !id_jump && !id_branch_taken && !id_call && id_ret)
          w_state_nxt = S_RET_WAIT;
      S_RET_WAIT: w_state_nxt = S_RUN;
      default:    w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    pc_writebar   = 1'b0;
    IF_ID_loadbar = 1'b0;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    pc_mux        = 2'b00;
    push          = 1'b0;
    pop           = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_hazard) begin
          pc_writebar   = 1'b1;
          IF_ID_loadbar = 1'b1;
          ID_EX_flush   = 1'b1;
        end else if (id_jump) begin
          pc_mux      = 2'b10;
          IF_ID_flush = 1'b1;
        end else if (id_branch_taken) begin
          pc_mux      = 2'b01;
          IF_ID_flush = 1'b1;
        end else if (id_call) begin
          pc_mux      = 2'b10;
          push        = 1'b1;
          IF_ID_flush = 1'b1;
        end else if (id_ret) begin
          pop           = 1'b1;
          pc_writebar   = 1'b1;
          IF_ID_loadbar = 1'b1;
          ID_EX_flush   = 1'b1;
        end
      end
      S_RET_WAIT: begin
        pc_mux      = 2'b11;
        IF_ID_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    forward_A       = r_ex.use_a ? f_fwd(r_mem, r_wb, r_ex.src_a) : 2'b00;
    forward_B       = r_ex.use_imm ? 2'b01 :
                      (r_ex.use_b ? f_fwd(r_mem, r_wb, r_ex.src_b) : 2'b00);
    forward_mem_EX  = (r_ex.is_store && r_ex.use_b) ? f_fwd(r_mem, r_wb, r_ex.src_b) : 2'b00;
    forward_mem_MEM = r_mem.is_store & r_wb.is_load & f_match(r_wb, r_mem.src_b);
  end

  assign stall_cycles = r_stall_cnt;

  // Slot fields carried for completeness but not consumed by later stages.
  assign w_unused = ^{r_mem.src_a, r_mem.use_a, r_mem.use_b, r_mem.use_imm,
                      r_wb.is_store, r_wb.src_a, r_wb.src_b, r_wb.use_a,
                      r_wb.use_b, r_wb.use_imm};

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: per-cycle expected control/forwarding
// vectors are queued as each ID instruction is driven and checked at negedge.
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  id_src_a, id_src_b, id_dst;
  logic        id_use_a, id_use_b, id_use_imm, id_reg_write;
  logic        id_is_load, id_is_store;
  logic        id_jump, id_branch_taken, id_call, id_ret;
  logic        pc_writebar, IF_ID_loadbar, IF_ID_flush, ID_EX_flush;
  logic [1:0]  pc_mux;
  logic        push, pop;
  logic [1:0]  forward_A, forward_B, forward_mem_EX;
  logic        forward_mem_MEM;
  logic [15:0] stall_cycles;

  hazard_sequencer #(.REG_AW(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_use_imm(id_use_imm),
    .id_reg_write(id_reg_write), .id_dst(id_dst),
    .id_is_load(id_is_load), .id_is_store(id_is_store),
    .id_jump(id_jump), .id_branch_taken(id_branch_taken),
    .id_call(id_call), .id_ret(id_ret),
    .pc_writebar(pc_writebar), .IF_ID_loadbar(IF_ID_loadbar),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .pc_mux(pc_mux), .push(push), .pop(pop),
    .forward_A(forward_A), .forward_B(forward_B),
    .forward_mem_EX(forward_mem_EX), .forward_mem_MEM(forward_mem_MEM),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sa, sb;
    logic       ua, ub, imm, rw;
    logic [2:0] dst;
    logic       ld, st, jmp, br, cal, ret;
  } id_t;

  typedef struct packed {
    logic [14:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  // ctl = {pc_writebar, IF_ID_loadbar, IF_ID_flush, ID_EX_flush, pc_mux, push, pop,
  //        forward_A, forward_B, forward_mem_EX, forward_mem_MEM}
  localparam logic [14:0] NONE   = 15'b000000000000000;
  localparam logic [14:0] STALL  = 15'b110100000000000;
  localparam logic [14:0] JMP_C  = 15'b001010000000000;
  localparam logic [14:0] BR_C   = 15'b001001000000000;
  localparam logic [14:0] CALL_C = 15'b001010100000000;
  localparam logic [14:0] RET1_C = 15'b110100010000000;
  localparam logic [14:0] RET2_C = 15'b001011000000000;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt = 16'd0;

  function automatic logic [14:0] fw(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [1:0] fme, input logic fmm);
    return {8'b0, fa, fb, fme, fmm};
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o.ctl = {pc_writebar, IF_ID_loadbar, IF_ID_flush, ID_EX_flush, pc_mux, push, pop,
             forward_A, forward_B, forward_mem_EX, forward_mem_MEM};
    o.cnt = stall_cycles;
    return o;
  endfunction

  function automatic id_t f_nop();
    return '0;
  endfunction

  function automatic id_t f_alu(input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    id_t t = '0;
    t.sa = a; t.sb = b; t.ua = 1'b1; t.ub = 1'b1; t.rw = 1'b1; t.dst = d;
    return t;
  endfunction

  function automatic id_t f_ld(input logic [2:0] d, input logic [2:0] a);
    id_t t = '0;
    t.sa = a; t.ua = 1'b1; t.imm = 1'b1; t.rw = 1'b1; t.dst = d; t.ld = 1'b1;
    return t;
  endfunction

  function automatic id_t f_st(input logic [2:0] addr, input logic [2:0] data);
    id_t t = '0;
    t.sa = addr; t.sb = data; t.ua = 1'b1; t.ub = 1'b1; t.imm = 1'b1; t.st = 1'b1;
    return t;
  endfunction

  function automatic id_t f_ctl(input logic j, input logic b, input logic c, input logic r);
    id_t t = '0;
    t.jmp = j; t.br = b; t.cal = c; t.ret = r;
    return t;
  endfunction

  task automatic drive(input id_t t);
    id_src_a = t.sa; id_src_b = t.sb; id_use_a = t.ua; id_use_b = t.ub;
    id_use_imm = t.imm; id_reg_write = t.rw; id_dst = t.dst;
    id_is_load = t.ld; id_is_store = t.st;
    id_jump = t.jmp; id_branch_taken = t.br; id_call = t.cal; id_ret = t.ret;
  endtask

  task automatic flush_pipe();
    drive(f_nop());
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    logic rst [2];
    exp_t e, g;
    rst = '{1'b1, 1'b0};
    exp_cnt = 16'd0;
    for (int i = 0; i < 2; i++) begin
      reset = rst[i];
      drive(f_nop());
      sb.push_back({NONE, exp_cnt});
      @(negedge clk);
      g = obs(); e = sb.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL reset[%0d]: ctl got %b want %b, stall_cycles got %0d want %0d", i, g.ctl, e.ctl, g.cnt, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    id_t st [4];
    logic [14:0] ex [4];
    exp_t e, g;
    st = '{f_ld(3, 1), f_alu(1, 3, 2), f_alu(1, 3, 2), f_nop()};
    ex = '{NONE, STALL | fw(2'b00, 2'b01, 2'b00, 1'b0), NONE, fw(2'b11, 2'b00, 2'b00, 1'b0)};
    for (int i = 0; i < 4; i++) begin
      drive(st[i]);
      sb.push_back({ex[i], exp_cnt});
      @(negedge clk);
      g = obs(); e = sb.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL load_use[%0d]: ctl got %b want %b, stall_cycles got %0d want %0d", i, g.ctl, e.ctl, g.cnt, e.cnt);
      end
      if (e.ctl[14] && !e.ctl[7] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_chain();
    id_t st [4];
    logic [14:0] ex [4];
    exp_t e, g;
    st = '{f_alu(3, 1, 2), f_alu(4, 3, 3), f_alu(5, 3, 1), f_nop()};
    ex = '{NONE, NONE, fw(2'b10, 2'b10, 2'b00, 1'b0), fw(2'b11, 2'b00, 2'b00, 1'b0)};
    for (int i = 0; i < 4; i++) begin
      drive(st[i]);
      sb.push_back({ex[i], exp_cnt});
      @(negedge clk);
      g = obs(); e = sb.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL alu_chain[%0d]: ctl got %b want %b, stall_cycles got %0d want %0d", i, g.ctl, e.ctl, g.cnt, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    id_t st [4];
    logic [14:0] ex [4];
    exp_t e, g;
    st = '{f_alu(3, 1, 1), f_alu(3, 2, 2), f_alu(6, 3, 3), f_nop()};
    ex = '{NONE, NONE, NONE, fw(2'b10, 2'b10, 2'b00, 1'b0)};
    for (int i = 0; i < 4; i++) begin
      drive(st[i]);
      sb.push_back({ex[i], exp_cnt});
      @(negedge clk);
      g = obs(); e = sb.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: ctl got %b want %b, stall_cycles got %0d want %0d", i, g.ctl, e.ctl, g.cnt, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_forward();
    id_t st [9];
    logic [14:0] ex [9];
    exp_t e, g;
    st = '{f_ld(2, 1), f_st(1, 2), f_nop(), f_nop(),
           f_alu(2, 1, 1), f_st(1, 2), f_st(4, 2), f_nop(), f_nop()};
    ex = '{NONE, fw(2'b00, 2'b01, 2'b00, 1'b0), fw(2'b00, 2'b01, 2'b00, 1'b0),
           fw(2'b00, 2'b00, 2'b00, 1'b1),
           NONE, NONE, fw(2'b00, 2'b01, 2'b10, 1'b0), fw(2'b00, 2'b01, 2'b11, 1'b0), NONE};
    for (int i = 0; i < 9; i++) begin
      drive(st[i]);
      sb.push_back({ex[i], exp_cnt});
      @(negedge clk);
      g = obs(); e = sb.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL store_forward[%0d]: ctl got %b want %b, stall_cycles got %0d want %0d", i, g.ctl, e.ctl, g.cnt, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_call_ret();
    id_t st [7];
    logic [14:0] ex [7];
    exp_t e, g;
    st = '{f_ctl(1'b1, 1'b0, 1'b0, 1'b0), f_nop(), f_ctl(1'b0, 1'b0, 1'b1, 1'b0), f_nop(),
           f_ctl(1'b0, 1'b0, 1'b0, 1'b1), f_ctl(1'b0, 1'b0, 1'b0, 1'b1), f_nop()};
    ex = '{JMP_C, NONE, CALL_C, NONE, RET1_C, RET2_C, NONE};
    for (int i = 0; i < 7; i++) begin
      drive(st[i]);
      sb.push_back({ex[i], exp_cnt});
      @(negedge clk);
      g = obs(); e = sb.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL call_ret[%0d]: ctl got %b want %b, stall_cycles got %0d want %0d", i, g.ctl, e.ctl, g.cnt, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    id_t st [4];
    id_t br;
    logic [14:0] ex [4];
    exp_t e, g;
    br = f_ctl(1'b0, 1'b1, 1'b0, 1'b0);
    br.sa = 3'd3; br.ua = 1'b1;
    st = '{f_ld(3, 1), br, br, f_nop()};
    ex = '{NONE, STALL | fw(2'b00, 2'b01, 2'b00, 1'b0), BR_C, fw(2'b11, 2'b00, 2'b00, 1'b0)};
    for (int i = 0; i < 4; i++) begin
      drive(st[i]);
      sb.push_back({ex[i], exp_cnt});
      @(negedge clk);
      g = obs(); e = sb.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL priority[%0d]: ctl got %b want %b, stall_cycles got %0d want %0d", i, g.ctl, e.ctl, g.cnt, e.cnt);
      end
      if (e.ctl[14] && !e.ctl[7] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ret_reset();
    id_t st [5];
    logic rst [5];
    logic [14:0] ex [5];
    exp_t e, g;
    st  = '{f_alu(3, 1, 2), f_ctl(1'b0, 1'b0, 1'b0, 1'b1), f_ctl(1'b0, 1'b0, 1'b0, 1'b1),
            f_alu(6, 3, 3), f_nop()};
    rst = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ex  = '{NONE, RET1_C, RET2_C, NONE, NONE};
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      reset = rst[i];
      sb.push_back({ex[i], exp_cnt});
      @(negedge clk);
      g = obs(); e = sb.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL ret_reset[%0d]: ctl got %b want %b, stall_cycles got %0d want %0d", i, g.ctl, e.ctl, g.cnt, e.cnt);
      end
      if (rst[i]) exp_cnt = 16'd0;
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(f_nop());
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    flush_pipe();
    test_load_use();
    flush_pipe();
    test_alu_chain();
    flush_pipe();
    test_back_to_back();
    flush_pipe();
    test_store_forward();
    flush_pipe();
    test_call_ret();
    flush_pipe();
    test_priority();
    flush_pipe();
    test_ret_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
